pu_msp430_inst_encoder: RTL
===========================

# pu_msp430_inst_encoder

Instruction encoder for the MSP430 bench: takes a symbolic instruction request (type, operation, byte/word, registers, addressing modes, extension values) and emits the corresponding MSP430 machine words (opcode, then optional source and destination extension words) on a valid/ready stream. It is the write-side counterpart of the bench instruction decoder/monitor. It feeds program-memory preload logic or an instruction-injection path, and counts the instructions it has encoded.

## Interface
- No parameters.
- mclk  in  1  main system clock
- puc_rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  encoder can accept request
- req_type  in  2  0=SIG-OP, 1=JUMP, 2=TWO-OP, 3=SWBRK
- req_op  in  4  TWO-OP: opcode[15:12] (4..15); SIG-OP: opcode[9:7] (0..6); JUMP: condition (0..7)
- req_bw  in  1  byte mode (.B)
- req_src  in  4  source register (SIG-OP: the single operand register)
- req_as  in  2  source addressing mode
- req_dst  in  4  destination register (TWO-OP only)
- req_ad  in  1  destination addressing mode (TWO-OP only)
- req_jmp_off  in  10  signed jump word offset
- req_src_ext  in  16  source extension value
- req_dst_ext  in  16  destination extension value
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts word
- out_word  out  16  machine word
- out_kind  out  2  0=OPCODE, 1=SRC_EXT, 2=DST_EXT
- out_last  out  1  final word of the instruction
- enc_err  out  1  one-cycle pulse: illegal request dropped
- inst_number  out  32  instructions fully emitted since reset

## Operation
- FSM states: IDLE, OPC, SRC_EXT, DST_EXT. req_ready=1 only in IDLE.
- On req_valid&req_ready, all request fields are registered, words computed, next state OPC. Illegal requests go to IDLE and pulse enc_err.
- TWO-OP word = {op, src, ad, bw, as, dst}. Illegal if op<4.
- SIG-OP word = {6'b000100, op[2:0], bw, as, src}. Illegal if op=7. For SWPB(1), SXT(3), CALL(5), RETI(6), bw is forced to 0. For RETI, as and src are also forced to 0 (word 16'h1300).
- JUMP word = {3'b001, op[2:0], req_jmp_off}. op[3] is ignored.
- Source extension needed (SIG-OP/TWO-OP):
  - as=01 with src≠r3;
  - as=11 with src=r0 (#N).
- No extension for r3 constants, or for r2 with as=10/11.
- Destination extension needed: TWO-OP with ad=1.
- Word order: OPC → SRC_EXT (if needed) → DST_EXT (if needed) → IDLE. out_last is set on the final word.
- inst_number increments on the handshake of the out_last word and wraps modulo 2^32.

## Timing
- Reset values: out_valid=0, out_word=0, out_kind=0, out_last=0, enc_err=0, inst_number=0, req_ready=1 (state IDLE).
- Latency: opcode is valid the cycle after request acceptance. Each subsequent word follows the cycle after the previous handshake.
- out_word, out_kind and out_last are held stable while out_valid&!out_ready.
- A new request is accepted no earlier than the cycle after the last-word handshake, i.e. there is one IDLE cycle between instructions.
- enc_err is asserted in the cycle after acceptance.
- puc_rst mid-instruction: the in-flight instruction is discarded and the block returns to IDLE. inst_number is cleared.

## Configuration
- PU_MSP430_ENC_SWBRK_EN defined: req_type=3 emits the single word `DBG_SWBRK_OP with out_last=1 and is counted in inst_number.
- Not defined: req_type=3 is illegal (enc_err pulse, no words emitted).

## Structure
- Shared package pu_msp430_pkg holds:
  - req_type and out_kind codes;
  - the FSM state enum;
  - SIG-OP/JUMP opcode-prefix constants.
- `DBG_SWBRK_OP stays in pu_msp430_defines.
- One combinational sub-module, pu_msp430_inst_word, maps request fields to: opcode word, need_src_ext, need_dst_ext, illegal.
- The top module owns the FSM, the output registers and the counter.

## Test plan
- MOV r4,r5 (type 2, op 4, src 4, as 00, ad 0, dst 5) → single word 16'h4405, out_last=1, one cycle after acceptance; inst_number=1.
- ADD.B #0x1234,x(r6) (op 5, src 0, as 11, bw 1, ad 1, dst 6, dst_ext 0x0010) → words 16'h50F6, 16'h1234, 16'h0010 with kinds 0/1/2. Hold out_ready low for 2 cycles on the second word → 16'h1234 is held stable.
- JMP offset -1 (type 1, op 7, off 10'h3FF) → 16'h3FFF; CALL #0xC000 (type 0, op 5, as 11, src 0) → 16'h12B0, 16'hC000.
- RETI with bw=1, as=11, src=9 → 16'h1300, single word. SIG-OP op 7 → enc_err pulse, no out_valid, inst_number unchanged.
- Assert puc_rst while the second of three words is pending → next cycle out_valid=0, req_ready=1, inst_number=0. A following MOV r4,r5 is emitted normally.
- req_type 3: with PU_MSP430_ENC_SWBRK_EN → `DBG_SWBRK_OP, last=1. Without the macro → enc_err only.

Source files
------------

// File: rtl/pu_msp430_pkg.sv
// Common codes for the MSP430 instruction encoder: request types, output word
// kinds, encoder FSM states and the fixed opcode prefixes.
package pu_msp430_pkg;

    typedef enum logic [1:0] {
        REQ_SIGOP = 2'd0,
        REQ_JUMP  = 2'd1,
        REQ_TWOOP = 2'd2,
        REQ_SWBRK = 2'd3
    } req_type_e;

    typedef enum logic [1:0] {
        KIND_OPC     = 2'd0,
        KIND_SRC_EXT = 2'd1,
        KIND_DST_EXT = 2'd2
    } out_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPC     = 2'd1,
        ST_SRC_EXT = 2'd2,
        ST_DST_EXT = 2'd3
    } enc_state_e;

    localparam logic [5:0] SIGOP_PREFIX = 6'b000100;
    localparam logic [2:0] JUMP_PREFIX  = 3'b001;

    localparam logic [2:0] SIGOP_SWPB = 3'd1;
    localparam logic [2:0] SIGOP_SXT  = 3'd3;
    localparam logic [2:0] SIGOP_CALL = 3'd5;
    localparam logic [2:0] SIGOP_RETI = 3'd6;

    // Indexed (x(Rn), absolute, symbolic) and immediate (@PC+) sources carry
    // an extension word; r3 constant-generator modes and r2 modes 10/11 do not.
    function automatic logic src_ext_needed(input logic [1:0] as_mode,
                                            input logic [3:0] src_reg);
        return ((as_mode == 2'b01) && (src_reg != 4'd3)) ||
               ((as_mode == 2'b11) && (src_reg == 4'd0));
    endfunction

endpackage

// File: rtl/pu_msp430_defines.sv
// Shared bench macros for the MSP430 instruction path.
// DBG_SWBRK_OP is the software-breakpoint opcode that the encoder emits for
// req_type=3 when PU_MSP430_ENC_SWBRK_EN is defined.
`ifndef PU_MSP430_DEFINES_SV
`define PU_MSP430_DEFINES_SV
`define DBG_SWBRK_OP 16'h4343
`endif

// File: rtl/pu_msp430_inst_word.sv
// Combinational mapping from request fields to the MSP430 opcode word plus
// the extension-word flags and an illegal-request flag.
// Macro: PU_MSP430_ENC_SWBRK_EN enables the software-breakpoint request type.
`ifdef PU_MSP430_ENC_SWBRK_EN
`include "pu_msp430_defines.sv"
`endif
module pu_msp430_inst_word
    import pu_msp430_pkg::*;
(
    input  logic [1:0]  req_type,
    input  logic [3:0]  op,
    input  logic        bw,
    input  logic [3:0]  src,
    input  logic [1:0]  as_mode,
    input  logic [3:0]  dst,
    input  logic        ad,
    input  logic [9:0]  jmp_off,
    output logic [15:0] opcode,
    output logic        need_src_ext,
    output logic        need_dst_ext,
    output logic        illegal
);

    logic       bw_eff;
    logic [1:0] as_eff;
    logic [3:0] src_eff;

    // Build the opcode and extension flags for each instruction format
    always_comb begin
        opcode       = 16'h0000;
        need_src_ext = 1'b0;
        need_dst_ext = 1'b0;
        illegal      = 1'b0;
        bw_eff       = bw;
        as_eff       = as_mode;
        src_eff      = src;
        case (req_type)
            REQ_TWOOP: begin
                opcode       = {op, src, ad, bw, as_mode, dst};
                need_src_ext = src_ext_needed(as_mode, src);
                need_dst_ext = ad;
                illegal      = (op < 4'd4);
            end
            REQ_SIGOP: begin
                // SWPB/SXT/CALL/RETI have no byte form; RETI has no operand
                if (op[2:0] == SIGOP_SWPB || op[2:0] == SIGOP_SXT ||
                    op[2:0] == SIGOP_CALL || op[2:0] == SIGOP_RETI)
                    bw_eff = 1'b0;
                if (op[2:0] == SIGOP_RETI) begin
                    as_eff  = 2'b00;
                    src_eff = 4'd0;
                end
                opcode       = {SIGOP_PREFIX, op[2:0], bw_eff, as_eff, src_eff};
                need_src_ext = src_ext_needed(as_eff, src_eff);
                illegal      = (op > 4'd6);
            end
            REQ_JUMP: begin
                opcode = {JUMP_PREFIX, op[2:0], jmp_off};
            end
            default: begin
`ifdef PU_MSP430_ENC_SWBRK_EN
                opcode = `DBG_SWBRK_OP;
`else
                illegal = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/pu_msp430_inst_encoder.sv
// MSP430 instruction encoder: accepts a symbolic request, emits opcode and
// optional source/destination extension words on a valid/ready stream, and
// counts fully emitted instructions.
// Macro: PU_MSP430_ENC_SWBRK_EN makes req_type=3 emit DBG_SWBRK_OP.
module pu_msp430_inst_encoder
    import pu_msp430_pkg::*;
(
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_type,
    input  logic [3:0]  req_op,
    input  logic        req_bw,
    input  logic [3:0]  req_src,
    input  logic [1:0]  req_as,
    input  logic [3:0]  req_dst,
    input  logic        req_ad,
    input  logic [9:0]  req_jmp_off,
    input  logic [15:0] req_src_ext,
    input  logic [15:0] req_dst_ext,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_word,
    output logic [1:0]  out_kind,
    output logic        out_last,
    output logic        enc_err,
    output logic [31:0] inst_number
);

    enc_state_e  state;
    logic [15:0] opcode;
    logic        need_src_ext;
    logic        need_dst_ext;
    logic        illegal;
    logic [15:0] src_ext_q;
    logic [15:0] dst_ext_q;
    logic        need_src_q;
    logic        need_dst_q;

    pu_msp430_inst_word u_word (
        .req_type     (req_type),
        .op           (req_op),
        .bw           (req_bw),
        .src          (req_src),
        .as_mode      (req_as),
        .dst          (req_dst),
        .ad           (req_ad),
        .jmp_off      (req_jmp_off),
        .opcode       (opcode),
        .need_src_ext (need_src_ext),
        .need_dst_ext (need_dst_ext),
        .illegal      (illegal)
    );

    assign req_ready = (state == ST_IDLE);

    // Encoder FSM: capture request, then step through the words on handshakes
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state       <= ST_IDLE;
            out_valid   <= 1'b0;
            out_word    <= 16'h0000;
            out_kind    <= KIND_OPC;
            out_last    <= 1'b0;
            enc_err     <= 1'b0;
            inst_number <= 32'd0;
            src_ext_q   <= 16'h0000;
            dst_ext_q   <= 16'h0000;
            need_src_q  <= 1'b0;
            need_dst_q  <= 1'b0;
        end else begin
            enc_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (illegal) begin
                            enc_err <= 1'b1;
                        end else begin
                            state      <= ST_OPC;
                            out_valid  <= 1'b1;
                            out_word   <= opcode;
                            out_kind   <= KIND_OPC;
                            out_last   <= !(need_src_ext || need_dst_ext);
                            src_ext_q  <= req_src_ext;
                            dst_ext_q  <= req_dst_ext;
                            need_src_q <= need_src_ext;
                            need_dst_q <= need_dst_ext;
                        end
                    end
                end
                default: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state       <= ST_IDLE;
                            out_valid   <= 1'b0;
                            inst_number <= inst_number + 32'd1;
                        end else if (state == ST_OPC && need_src_q) begin
                            state    <= ST_SRC_EXT;
                            out_word <= src_ext_q;
                            out_kind <= KIND_SRC_EXT;
                            out_last <= !need_dst_q;
                        end else begin
                            state    <= ST_DST_EXT;
                            out_word <= dst_ext_q;
                            out_kind <= KIND_DST_EXT;
                            out_last <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
